// File: rtl/epp_frame_loader.sv
// EPP slave that decodes host address/data cycles into a small register file and
// assembles host bytes into pixels streamed downstream with frame/line markers.
module epp_frame_loader #(
    parameter int IMG_W       = 512,
    parameter int IMG_H       = 512,
    parameter int PIX_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_sys,
    input  logic             rst_sys,
    input  logic             EPP_Write0,
    input  logic             EPP_DataStrobe0,
    input  logic             EPP_AddressStrobe0,
    input  logic             EPP_Reset0,
    input  logic [7:0]       epp_din,
    output logic [7:0]       epp_dout,
    output logic             epp_doe,
    output logic             EPP_Wait,
    output logic             EPP_Interrupt,
    output logic [PIX_W-1:0] pix_data,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             pix_sof,
    output logic             pix_eol,
    output logic             pix_eof,
    output logic             frame_busy
);

    localparam int BPP = (PIX_W + 7) / 8;
    localparam int BCW = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int CW  = $clog2(IMG_W);
    localparam int LW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [BCW-1:0] BYTE_LAST = BCW'(BPP - 1);
    localparam logic [CW-1:0]  COL_LAST  = CW'(IMG_W - 1);
    localparam logic [LW-1:0]  LINE_LAST = LW'(IMG_H - 1);
    localparam logic [1:0] REG_CTRL = 2'd0, REG_DATA = 2'd1, REG_STATUS = 2'd2, REG_FCNT = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DWR, S_PIXW, S_DRD, S_ACK} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] nrst_sync, astb_sync, dstb_sync, wr_sync;
    logic [7:0]             din_sync [SYNC_STAGES];
    logic                   rst, astb_s, dstb_s, wr_s;
    logic [7:0]             din_s, rd_data, frame_cnt;
    logic [1:0]             addr_reg;
    logic [BCW-1:0]         bcnt;
    logic [CW-1:0]          col_cnt;
    logic [LW-1:0]          lin_cnt;
    logic [BPP*8-1:0]       asm_bytes, asm_next;
    logic                   armed, done, err, pix_stall;

    // The host reset chain is never reset itself so it cannot hold itself in reset.
    always_ff @(posedge clk_sys) begin
        nrst_sync   <= {nrst_sync[SYNC_STAGES-2:0], EPP_Reset0};
        din_sync[0] <= epp_din;
        for (int i = 1; i < SYNC_STAGES; i++) din_sync[i] <= din_sync[i-1];
    end

    assign rst = rst_sys | ~nrst_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            astb_sync <= '1;
            dstb_sync <= '1;
            wr_sync   <= '1;
        end else begin
            astb_sync <= {astb_sync[SYNC_STAGES-2:0], EPP_AddressStrobe0};
            dstb_sync <= {dstb_sync[SYNC_STAGES-2:0], EPP_DataStrobe0};
            wr_sync   <= {wr_sync[SYNC_STAGES-2:0], EPP_Write0};
        end
    end

    assign astb_s        = astb_sync[SYNC_STAGES-1];
    assign dstb_s        = dstb_sync[SYNC_STAGES-1];
    assign wr_s          = wr_sync[SYNC_STAGES-1];
    assign din_s         = din_sync[SYNC_STAGES-1];
    assign pix_stall     = pix_valid && !pix_ready;
    assign EPP_Interrupt = done;
    // armed drops on the eof handshake, so armed alone means "frame in progress".
    assign frame_busy    = armed;

    always_comb begin
        asm_next = asm_bytes;
        for (int i = 0; i < BPP; i++)
            if (bcnt == BCW'(i)) asm_next[i*8 +: 8] = din_s;
    end

    always_comb begin
        rd_data = 8'h00;
        case (addr_reg)
            REG_CTRL:   rd_data = {7'b0, armed};
            REG_DATA:   rd_data = 8'h00;
            REG_STATUS: rd_data = {4'b0, armed, err, done, armed};
            REG_FCNT:   rd_data = frame_cnt;
            default:    rd_data = 8'h00;
        endcase
    end

    // IDLE only sees low strobes after ACK has waited for release, so the level acts as the falling edge.
    always_comb begin
        state_nxt = state;
        EPP_Wait  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!astb_s)      state_nxt = S_ADDR;
                else if (!dstb_s) state_nxt = wr_s ? S_DRD : S_DWR;
            end
            S_ADDR: state_nxt = S_ACK;
            S_DWR:  state_nxt = (addr_reg == REG_DATA) ? S_PIXW : S_ACK;
            S_PIXW: if (!(armed && bcnt == BYTE_LAST && pix_stall)) state_nxt = S_ACK;
            S_DRD:  state_nxt = S_ACK;
            S_ACK: begin
                EPP_Wait = 1'b1;
                if (astb_s && dstb_s) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk_sys) begin
        if (state == S_PIXW && armed && bcnt != BYTE_LAST) asm_bytes <= asm_next;
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            addr_reg  <= '0;
            bcnt      <= '0;
            col_cnt   <= '0;
            lin_cnt   <= '0;
            frame_cnt <= '0;
            armed     <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            epp_dout  <= '0;
            epp_doe   <= 1'b0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            pix_eof   <= 1'b0;
        end else begin
            if (pix_valid && pix_ready) begin
                pix_valid <= 1'b0;
                if (pix_eof) begin
                    done      <= 1'b1;
                    armed     <= 1'b0;
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
            case (state)
                S_ADDR: begin
                    if (!wr_s) addr_reg <= din_s[1:0];
                    else begin
                        epp_dout <= {6'b0, addr_reg};
                        epp_doe  <= 1'b1;
                    end
                end
                // Register writes come after the handshake so a host command wins a same-cycle tie.
                S_DWR: begin
                    if (addr_reg == REG_CTRL) begin
                        if (din_s[1]) begin
                            armed     <= 1'b0;
                            bcnt      <= '0;
                            col_cnt   <= '0;
                            lin_cnt   <= '0;
                            pix_valid <= 1'b0;
                        end else if (din_s[0]) begin
                            armed   <= 1'b1;
                            done    <= 1'b0;
                            err     <= 1'b0;
                            bcnt    <= '0;
                            col_cnt <= '0;
                            lin_cnt <= '0;
                        end
                        if (din_s[2]) done <= 1'b0;
                    end
                end
                S_PIXW: begin
                    if (!armed) err <= 1'b1;
                    else if (bcnt != BYTE_LAST) bcnt <= bcnt + BCW'(1);
                    else if (!pix_stall) begin
                        pix_valid <= 1'b1;
                        pix_data  <= asm_next[PIX_W-1:0];
                        pix_sof   <= (col_cnt == '0) && (lin_cnt == '0);
                        pix_eol   <= (col_cnt == COL_LAST);
                        pix_eof   <= (col_cnt == COL_LAST) && (lin_cnt == LINE_LAST);
                        bcnt      <= '0;
                        if (col_cnt == COL_LAST) begin
                            col_cnt <= '0;
                            lin_cnt <= (lin_cnt == LINE_LAST) ? '0 : lin_cnt + LW'(1);
                        end else begin
                            col_cnt <= col_cnt + CW'(1);
                        end
                    end
                end
                S_DRD: begin
                    epp_dout <= rd_data;
                    epp_doe  <= 1'b1;
                end
                S_ACK: if (astb_s && dstb_s) epp_doe <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_epp_frame_loader.sv
// Bench for epp_frame_loader: host EPP cycles, a pixel sink with optional random
// backpressure, and a frame model that derives markers from pixel index.
module tb_epp_frame_loader;

    localparam int W = 4, H = 2, SYNC = 2, NPIX = W * H;

    logic clk = 1'b0;
    logic rst_sys = 1'b1, wr0 = 1'b1, dstb0 = 1'b1, astb0 = 1'b1, nrst0 = 1'b1;
    logic [7:0] din = 8'h00;
    logic pix_ready_a = 1'b1, ready_b = 1'b1, sel = 1'b0;

    logic [7:0]  dout_a, dout_b, pd_a;
    logic [11:0] pd_b;
    logic doe_a, wait_a, irq_a, pv_a, sof_a, eol_a, eof_a, busy_a;
    logic doe_b, wait_b, irq_b, pv_b, sof_b, eol_b, eof_b, busy_b;

    int n_pass = 0, n_total = 0, bus_tmo = 0, ready_mode = 0, exp_frames = 0;
    logic [10:0] rx_a[$];
    logic [14:0] rx_b[$];

    always #5 clk = ~clk;

    epp_frame_loader #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .SYNC_STAGES(SYNC)) dut_a (
        .clk_sys(clk), .rst_sys(rst_sys), .EPP_Write0(wr0), .EPP_DataStrobe0(dstb0),
        .EPP_AddressStrobe0(astb0), .EPP_Reset0(nrst0), .epp_din(din), .epp_dout(dout_a),
        .epp_doe(doe_a), .EPP_Wait(wait_a), .EPP_Interrupt(irq_a), .pix_data(pd_a),
        .pix_valid(pv_a), .pix_ready(pix_ready_a), .pix_sof(sof_a), .pix_eol(eol_a),
        .pix_eof(eof_a), .frame_busy(busy_a));

    epp_frame_loader #(.IMG_W(W), .IMG_H(H), .PIX_W(12), .SYNC_STAGES(SYNC)) dut_b (
        .clk_sys(clk), .rst_sys(rst_sys), .EPP_Write0(wr0), .EPP_DataStrobe0(dstb0),
        .EPP_AddressStrobe0(astb0), .EPP_Reset0(nrst0), .epp_din(din), .epp_dout(dout_b),
        .epp_doe(doe_b), .EPP_Wait(wait_b), .EPP_Interrupt(irq_b), .pix_data(pd_b),
        .pix_valid(pv_b), .pix_ready(ready_b), .pix_sof(sof_b), .pix_eol(eol_b),
        .pix_eof(eof_b), .frame_busy(busy_b));

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: pix_ready_a = 1'b1;
            1: pix_ready_a = 1'($urandom_range(0, 1));
            default: pix_ready_a = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (pv_a && pix_ready_a) rx_a.push_back({sof_a, eol_a, eof_a, pd_a});
        if (pv_b && ready_b) rx_b.push_back({sof_b, eol_b, eof_b, pd_b});
    end

    // Reference: markers are a pure function of the pixel's position in the frame.
    function automatic logic [10:0] exp_pix(input int i, input logic [7:0] d);
        return {i == 0, (i % W) == W - 1, i == NPIX - 1, d};
    endfunction

    task automatic epp_cycle(input bit is_addr, input bit is_write, input logic [7:0] wdata,
                             input int limit, output logic [7:0] rdata, output int lat);
        int n;
        @(negedge clk);
        wr0 = ~is_write;
        din = wdata;
        if (is_addr) astb0 = 1'b0; else dstb0 = 1'b0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end
        while (!(sel ? wait_b : wait_a) && lat < limit);
        if (!(sel ? wait_b : wait_a)) bus_tmo++;
        rdata = sel ? dout_b : dout_a;
        @(negedge clk);
        astb0 = 1'b1; dstb0 = 1'b1; wr0 = 1'b1;
        n = 0;
        while ((wait_a || wait_b) && n < 50) begin @(posedge clk); #1; n++; end
        if (wait_a || wait_b) bus_tmo++;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] rd; int lat;
        epp_cycle(1'b1, 1'b1, {6'b0, a}, 100, rd, lat);
        epp_cycle(1'b0, 1'b1, d, 100, rd, lat);
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [7:0] d);
        int lat;
        epp_cycle(1'b1, 1'b1, {6'b0, a}, 100, d, lat);
        epp_cycle(1'b0, 1'b0, 8'h00, 100, d, lat);
    endtask

    task automatic wr_byte(input logic [7:0] d);
        logic [7:0] rd; int lat;
        epp_cycle(1'b0, 1'b1, d, 200, rd, lat);
    endtask

    task automatic wait_rx_a(input int cnt);
        int n = 0;
        while (rx_a.size() < cnt && n < 1000) begin @(posedge clk); n++; end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] rd; int lat;
        rst_sys = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({wait_a, irq_a, pv_a, busy_a, doe_a, dout_a, pd_a, sof_a, eol_a, eof_a} !== '0)
            $display("FAIL reset_outputs: got %0h required 0",
                     {wait_a, irq_a, pv_a, busy_a, doe_a, dout_a, pd_a, sof_a, eol_a, eof_a});
        else n_pass++;
        @(negedge clk) rst_sys = 1'b0;
        epp_cycle(1'b1, 1'b1, 8'h02, 100, rd, lat);
        n_total++;
        if (lat !== SYNC + 2) $display("FAIL addr_ack_latency: got %0d required %0d", lat, SYNC + 2);
        else n_pass++;
        epp_cycle(1'b0, 1'b0, 8'h00, 100, rd, lat);
        n_total++;
        if (rd !== 8'h00) $display("FAIL status_after_reset: got %0h required 00", rd);
        else n_pass++;
        n_total++;
        if (lat !== SYNC + 2) $display("FAIL read_ack_latency: got %0d required %0d", lat, SYNC + 2);
        else n_pass++;
        epp_cycle(1'b1, 1'b0, 8'h00, 100, rd, lat);
        n_total++;
        if (rd !== 8'h02) $display("FAIL addr_readback: got %0h required 02", rd);
        else n_pass++;
    endtask

    task automatic test_frame_basic();
        logic [7:0] rd;
        ready_mode = 0;
        rx_a.delete();
        reg_write(2'd0, 8'h01);
        reg_write(2'd1, 8'h10);
        for (int i = 1; i < NPIX; i++) wr_byte(8'(8'h10 + i));
        wait_rx_a(NPIX);
        exp_frames++;
        n_total++;
        if (rx_a.size() !== NPIX) $display("FAIL basic_count: got %0d required %0d", rx_a.size(), NPIX);
        else n_pass++;
        for (int i = 0; i < NPIX && i < rx_a.size(); i++) begin
            n_total++;
            if (rx_a[i] !== exp_pix(i, 8'(8'h10 + i)))
                $display("FAIL basic_pix%0d: got %0h required %0h", i, rx_a[i], exp_pix(i, 8'(8'h10 + i)));
            else n_pass++;
        end
        n_total++;
        if (irq_a !== 1'b1) $display("FAIL basic_irq: got %0b required 1", irq_a);
        else n_pass++;
        reg_read(2'd3, rd);
        n_total++;
        if (rd !== 8'(exp_frames)) $display("FAIL basic_frame_cnt: got %0h required %0h", rd, 8'(exp_frames));
        else n_pass++;
        reg_read(2'd2, rd);
        n_total++;
        if (rd !== 8'h02) $display("FAIL basic_status: got %0h required 02", rd);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] rd; int lat4; int bad;
        ready_mode = 0;
        rx_a.delete();
        reg_write(2'd0, 8'h01);
        reg_write(2'd1, 8'h10);
        wr_byte(8'h11);
        ready_mode = 2;
        wr_byte(8'h12);
        bad = 0;
        lat4 = 0;
        fork
            epp_cycle(1'b0, 1'b1, 8'h13, 200, rd, lat4);
            begin
                repeat (20) begin
                    @(posedge clk); #2;
                    if (!(pv_a && pd_a == 8'h12 && !wait_a)) bad++;
                end
                ready_mode = 0;
            end
        join
        n_total++;
        if (bad !== 0) $display("FAIL stall_hold: got %0d bad cycles required 0", bad);
        else n_pass++;
        n_total++;
        if (lat4 <= 20) $display("FAIL stall_wait_latency: got %0d required >20", lat4);
        else n_pass++;
        for (int i = 4; i < NPIX; i++) wr_byte(8'(8'h10 + i));
        wait_rx_a(NPIX);
        exp_frames++;
        n_total++;
        if (rx_a.size() !== NPIX) $display("FAIL stall_count: got %0d required %0d", rx_a.size(), NPIX);
        else n_pass++;
        for (int i = 0; i < NPIX && i < rx_a.size(); i++) begin
            n_total++;
            if (rx_a[i] !== exp_pix(i, 8'(8'h10 + i)))
                $display("FAIL stall_pix%0d: got %0h required %0h", i, rx_a[i], exp_pix(i, 8'(8'h10 + i)));
            else n_pass++;
        end
        reg_read(2'd3, rd);
        n_total++;
        if (rd !== 8'(exp_frames)) $display("FAIL stall_frame_cnt: got %0h required %0h", rd, 8'(exp_frames));
        else n_pass++;
    endtask

    task automatic run_random_frame(input string tag);
        logic [7:0] bytes [NPIX];
        logic [7:0] rd;
        rx_a.delete();
        for (int i = 0; i < NPIX; i++) bytes[i] = 8'($urandom);
        reg_write(2'd0, 8'h01);
        reg_write(2'd1, bytes[0]);
        for (int i = 1; i < NPIX; i++) wr_byte(bytes[i]);
        wait_rx_a(NPIX);
        exp_frames++;
        n_total++;
        if (rx_a.size() !== NPIX) $display("FAIL %s_count: got %0d required %0d", tag, rx_a.size(), NPIX);
        else n_pass++;
        for (int i = 0; i < NPIX && i < rx_a.size(); i++) begin
            n_total++;
            if (rx_a[i] !== exp_pix(i, bytes[i]))
                $display("FAIL %s_pix%0d: got %0h required %0h", tag, i, rx_a[i], exp_pix(i, bytes[i]));
            else n_pass++;
        end
        n_total++;
        if (irq_a !== 1'b1 || busy_a !== 1'b0)
            $display("FAIL %s_done: got irq=%0b busy=%0b required irq=1 busy=0", tag, irq_a, busy_a);
        else n_pass++;
        reg_read(2'd3, rd);
        n_total++;
        if (rd !== 8'(exp_frames)) $display("FAIL %s_frame_cnt: got %0h required %0h", tag, rd, 8'(exp_frames));
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [7:0] rd;
        ready_mode = 0;
        rx_a.delete();
        reg_write(2'd0, 8'h01);
        reg_write(2'd1, 8'h20);
        wr_byte(8'h21);
        ready_mode = 2;
        wr_byte(8'h22);
        n_total++;
        if (pv_a !== 1'b1) $display("FAIL abort_pending: got %0b required 1", pv_a);
        else n_pass++;
        reg_write(2'd0, 8'h03);
        n_total++;
        if (pv_a !== 1'b0 || busy_a !== 1'b0)
            $display("FAIL abort_drop: got valid=%0b busy=%0b required 0 0", pv_a, busy_a);
        else n_pass++;
        ready_mode = 0;
        reg_write(2'd1, 8'hAA);
        repeat (4) @(posedge clk);
        reg_read(2'd2, rd);
        n_total++;
        if (rd !== 8'h04) $display("FAIL abort_status: got %0h required 04", rd);
        else n_pass++;
        n_total++;
        if (irq_a !== 1'b0 || rx_a.size() !== 2)
            $display("FAIL abort_no_irq: got irq=%0b pixels=%0d required 0 2", irq_a, rx_a.size());
        else n_pass++;
        run_random_frame("rearm");
    endtask

    task automatic test_random_frames();
        ready_mode = 1;
        for (int f = 0; f < 3; f++) run_random_frame($sformatf("rand%0d", f));
        ready_mode = 0;
    endtask

    task automatic test_wide_pixel();
        sel = 1'b1;
        reg_write(2'd0, 8'h01);
        reg_write(2'd1, 8'h34);
        repeat (4) @(posedge clk);
        rx_b.delete();
        n_total++;
        if (pv_b !== 1'b0) $display("FAIL wide_half: got valid=%0b required 0", pv_b);
        else n_pass++;
        wr_byte(8'hF2);
        repeat (4) @(posedge clk);
        n_total++;
        if (rx_b.size() !== 1) $display("FAIL wide_count: got %0d required 1", rx_b.size());
        else n_pass++;
        n_total++;
        if (rx_b.size() > 0 && rx_b[0] !== {3'b100, 12'h234})
            $display("FAIL wide_pix: got %0h required %0h", rx_b[0], {3'b100, 12'h234});
        else n_pass++;
        sel = 1'b0;
    endtask

    task automatic test_host_reset();
        logic [7:0] rd;
        ready_mode = 0;
        reg_write(2'd0, 8'h01);
        reg_write(2'd1, 8'h55);
        wr_byte(8'h66);
        wr_byte(8'h77);
        n_total++;
        if (busy_a !== 1'b1) $display("FAIL hrst_pre_busy: got %0b required 1", busy_a);
        else n_pass++;
        @(negedge clk) nrst0 = 1'b0;
        repeat (SYNC + 2) @(posedge clk);
        #1;
        n_total++;
        if ({wait_a, irq_a, pv_a, busy_a, doe_a, dout_a, pd_a, sof_a, eol_a, eof_a} !== '0)
            $display("FAIL hrst_outputs: got %0h required 0",
                     {wait_a, irq_a, pv_a, busy_a, doe_a, dout_a, pd_a, sof_a, eol_a, eof_a});
        else n_pass++;
        @(negedge clk) nrst0 = 1'b1;
        repeat (SYNC + 3) @(posedge clk);
        reg_read(2'd3, rd);
        n_total++;
        if (rd !== 8'h00) $display("FAIL hrst_frame_cnt: got %0h required 00", rd);
        else n_pass++;
        reg_read(2'd2, rd);
        n_total++;
        if (rd !== 8'h00 || busy_a !== 1'b0)
            $display("FAIL hrst_status: got %0h busy=%0b required 00 0", rd, busy_a);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_frame_basic();
        test_backpressure();
        test_abort();
        test_random_frames();
        test_wide_pixel();
        test_host_reset();
        n_total++;
        if (bus_tmo !== 0) $display("FAIL bus_timeouts: got %0d required 0", bus_tmo);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
